// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encoding and its width.
package imm_ext_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus for the immediate extender: input channel plus result channel.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [MODE_W-1:0] in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [MODE_W-1:0] out_mode;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_mode
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_mode
    );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate widening by mode: zero, sign, upper placement, shifted sign.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  result_c
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_c;

    assign sign_c = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        result_c = '0;
        case (imm_mode_e'(mode))
            IMM_ZERO:   result_c = OUT_W'(imm);
            IMM_SIGN:   result_c = sign_c;
            IMM_UPPER:  result_c = {imm, {PAD_W{1'b0}}};
            IMM_BRANCH: result_c = sign_c << BR_SHIFT;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with output register; define IMM_EXT_SKID_EN for a
// one-entry skid buffer that makes in_ready a registered signal.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    imm_extend_pipe_if.slave bus
);

    if (IN_W < 2 || IN_W >= OUT_W || TAG_W < 1 || BR_SHIFT > OUT_W - IN_W) begin : g_bad_params
        $error("imm_extend_pipe: illegal IN_W/OUT_W/TAG_W/BR_SHIFT combination");
    end

    logic [OUT_W-1:0]  ext_c;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [MODE_W-1:0] out_mode_q;
    logic              out_free_c;
    logic              push_c;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm      (bus.in_imm),
        .mode     (bus.in_mode),
        .result_c (ext_c)
    );

    assign out_free_c    = !out_valid_q || bus.out_ready;
    assign push_c        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_mode  = out_mode_q;

`ifdef IMM_EXT_SKID_EN
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [OUT_W-1:0]  skid_data_q;
    logic [TAG_W-1:0]  skid_tag_q;
    logic [MODE_W-1:0] skid_mode_q;
    logic              in_ready_q;

    // in_ready is the registered "skid empty" flag; reset_n only forces it low.
    assign bus.in_ready = reset_n && in_ready_q;

    always_comb begin
        skid_valid_d = skid_valid_q;
        if (out_free_c && skid_valid_q) begin
            skid_valid_d = 1'b0;
        end else if (!out_free_c && push_c) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_mode_q   <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (out_free_c) begin
                // Skid drains first so acceptance order is preserved.
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= skid_data_q;
                    out_tag_q   <= skid_tag_q;
                    out_mode_q  <= skid_mode_q;
                end else if (push_c) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= ext_c;
                    out_tag_q   <= bus.in_tag;
                    out_mode_q  <= bus.in_mode;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (push_c) begin
                skid_data_q <= ext_c;
                skid_tag_q  <= bus.in_tag;
                skid_mode_q <= bus.in_mode;
            end
        end
    end
`else
    logic live_q;

    // live_q keeps in_ready low until the first clock after reset release.
    assign bus.in_ready = reset_n && live_q && out_free_c;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_mode_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (out_free_c) begin
                if (push_c) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= ext_c;
                    out_tag_q   <= bus.in_tag;
                    out_mode_q  <= bus.in_mode;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
